// File: rtl/fetch_mon_pkg.sv
// Shared constants for the instruction-fetch monitor.
// Build option: FETCH_MON_TRACE_EN enables the fetch trace buffer.
package fetch_mon_pkg;

  localparam int ADDR_W          = 32;
  localparam int DEF_ROM_BYTES   = 8192;
  localparam int DEF_HALT_THRESH = 16;
  localparam int DEF_HIST_DEPTH  = 8;
  localparam int DEF_CNT_W       = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  function automatic logic misaligned(input addr_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_mon_trace.sv
// Circular history of recent fetch addresses, newest at index 0.
// Only instantiated when FETCH_MON_TRACE_EN is defined.
module fetch_mon_trace
  import fetch_mon_pkg::*;
#(
  parameter int HIST_DEPTH = DEF_HIST_DEPTH,
  localparam int IDX_W = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  addr_t            wr_addr,
  input  logic [IDX_W-1:0] rd_idx,
  output addr_t            rd_addr
);

  addr_t            mem [HIST_DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_addr;
      wr_ptr      <= wr_ptr + IDX_W'(1);
    end
  end

  // Pointer arithmetic wraps naturally at power-of-2 depth.
  always_comb begin
    rd_ptr  = wr_ptr - IDX_W'(1) - rd_idx;
    rd_addr = mem[rd_ptr];
  end

endmodule

// File: rtl/fetch_monitor.sv
// Passive fetch-port observer: counts, halt detect, fetch error flags.
// Build option: FETCH_MON_TRACE_EN adds hist_rd_idx/hist_rd_addr trace port.
module fetch_monitor
  import fetch_mon_pkg::*;
#(
  parameter int ROM_BYTES   = DEF_ROM_BYTES,
  parameter int HALT_THRESH = DEF_HALT_THRESH,
  parameter int HIST_DEPTH  = DEF_HIST_DEPTH,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rom_en,
  input  addr_t            rom_addr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] fetch_cnt,
  output addr_t            last_addr,
  output logic             last_valid,
  output logic             halted,
  output logic             misalign_err,
  output logic             range_err,
`ifdef FETCH_MON_TRACE_EN
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output addr_t            hist_rd_addr,
`endif
  output addr_t            err_addr
);

  localparam int    RPT_W    = $clog2(HALT_THRESH);
  localparam addr_t ADDR_MAX = ADDR_W'(ROM_BYTES - 4);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(HALT_THRESH - 1);

  logic [RPT_W-1:0] rpt;
  logic [RPT_W-1:0] rpt_nxt;
  logic             same;
  logic             mis_hit;
  logic             rng_hit;
  logic             err_hit;
  logic             mis_base;
  logic             rng_base;

  always_comb begin
    same    = last_valid && (rom_addr == last_addr);
    rpt_nxt = '0;
    if (same)
      rpt_nxt = (rpt == RPT_MAX) ? rpt : rpt + RPT_W'(1);
    mis_hit  = rom_en && misaligned(rom_addr);
    rng_hit  = rom_en && (rom_addr > ADDR_MAX);
    err_hit  = mis_hit || rng_hit;
    mis_base = misalign_err && !err_clr;
    rng_base = range_err && !err_clr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt  <= '0;
      last_addr  <= '0;
      last_valid <= 1'b0;
      rpt        <= '0;
      halted     <= 1'b0;
    end else if (rom_en) begin
      if (fetch_cnt != '1)
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      last_addr  <= rom_addr;
      last_valid <= 1'b1;
      rpt        <= rpt_nxt;
      halted     <= (rpt_nxt == RPT_MAX);
    end
  end

  // err_addr keeps the first error; a same-cycle clear lets a new one in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
      err_addr     <= '0;
    end else begin
      misalign_err <= mis_base || mis_hit;
      range_err    <= rng_base || rng_hit;
      if (err_hit && !(mis_base || rng_base))
        err_addr <= rom_addr;
      else if (err_clr)
        err_addr <= '0;
    end
  end

`ifdef FETCH_MON_TRACE_EN
  fetch_mon_trace #(
    .HIST_DEPTH(HIST_DEPTH)
  ) u_trace (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (rom_en),
    .wr_addr(rom_addr),
    .rd_idx (hist_rd_idx),
    .rd_addr(hist_rd_addr)
  );
`endif

endmodule

// File: tb/tb_fetch_monitor.sv
// Directed bench for fetch_monitor, default and 4-bit counter builds.
// Trace checks are compiled in with FETCH_MON_TRACE_EN.
module tb_fetch_monitor;
  import fetch_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en;
  addr_t       rom_addr;
  logic        err_clr;
  logic [31:0] fetch_cnt;
  addr_t       last_addr;
  logic        last_valid;
  logic        halted;
  logic        misalign_err;
  logic        range_err;
  addr_t       err_addr;
  logic [3:0]  s_cnt;
  addr_t       s_last_addr;
  logic        s_last_valid;
  logic        s_halted;
  logic        s_mis;
  logic        s_rng;
  addr_t       s_err_addr;
`ifdef FETCH_MON_TRACE_EN
  logic [2:0]  hist_rd_idx;
  addr_t       hist_rd_addr;
  logic [2:0]  s_idx;
  addr_t       s_hist;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .err_clr     (err_clr),
    .fetch_cnt   (fetch_cnt),
    .last_addr   (last_addr),
    .last_valid  (last_valid),
    .halted      (halted),
    .misalign_err(misalign_err),
    .range_err   (range_err),
`ifdef FETCH_MON_TRACE_EN
    .hist_rd_idx (hist_rd_idx),
    .hist_rd_addr(hist_rd_addr),
`endif
    .err_addr    (err_addr)
  );

  fetch_monitor #(.CNT_W(4)) dut_small (
    .clk         (clk),
    .rst         (rst),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .err_clr     (err_clr),
    .fetch_cnt   (s_cnt),
    .last_addr   (s_last_addr),
    .last_valid  (s_last_valid),
    .halted      (s_halted),
    .misalign_err(s_mis),
    .range_err   (s_rng),
`ifdef FETCH_MON_TRACE_EN
    .hist_rd_idx (s_idx),
    .hist_rd_addr(s_hist),
`endif
    .err_addr    (s_err_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input addr_t a);
    rom_en   = 1'b1;
    rom_addr = a;
    tick();
    rom_en   = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic idle();
    rom_en = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    rom_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    rom_en   = 1'b1;
    rom_addr = 32'h40;
    err_clr  = 1'b0;
`ifdef FETCH_MON_TRACE_EN
    hist_rd_idx = '0;
    s_idx       = '0;
`endif
    // 1: reset held with fetch strobe active
    tick();
    tick();
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_last", last_addr, 0);
    chk("rst_valid", 32'(last_valid), 0);
    chk("rst_halt", 32'(halted), 0);
    chk("rst_mis", 32'(misalign_err), 0);
    chk("rst_rng", 32'(range_err), 0);
    chk("rst_eaddr", err_addr, 0);
    rst = 1'b1;
    fetch(32'h40);
    chk("rel_cnt", fetch_cnt, 1);
    chk("rel_last", last_addr, 32'h40);
    chk("rel_valid", 32'(last_valid), 1);

    // 2: sequential fetches with gaps
    do_reset();
    fetch(32'h0);
    idle();
    fetch(32'h4);
    idle();
    fetch(32'h8);
    chk("seq_cnt", fetch_cnt, 3);
    chk("seq_last", last_addr, 32'h8);
    chk("seq_halt", 32'(halted), 0);
    chk("seq_mis", 32'(misalign_err), 0);
    chk("seq_rng", 32'(range_err), 0);

    // 3: self-loop detection, idle cycles must not break the run
    for (int i = 0; i < 15; i++) begin
      fetch(32'h100);
      if (i % 3 == 1) idle();
    end
    chk("halt_15", 32'(halted), 0);
    fetch(32'h100);
    chk("halt_16", 32'(halted), 1);
    idle();
    chk("halt_idle", 32'(halted), 1);
    fetch(32'h100);
    chk("halt_17", 32'(halted), 1);
    fetch(32'h104);
    chk("halt_exit", 32'(halted), 0);
    chk("halt_cnt", fetch_cnt, 3 + 17 + 1);

    // 4: error flags, first-error capture, clear vs new error
    do_reset();
    fetch(32'h2);
    chk("e_mis1", 32'(misalign_err), 1);
    chk("e_rng1", 32'(range_err), 0);
    chk("e_addr1", err_addr, 32'h2);
    fetch(32'h2000);
    chk("e_rng2", 32'(range_err), 1);
    chk("e_addr2", err_addr, 32'h2);
    err_clr = 1'b1;
    fetch(32'h3000);
    chk("e_mis3", 32'(misalign_err), 0);
    chk("e_rng3", 32'(range_err), 1);
    chk("e_addr3", err_addr, 32'h3000);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk("e_clr_rng", 32'(range_err), 0);
    chk("e_clr_addr", err_addr, 0);
    fetch(32'h1FFC);
    chk("e_top_ok", 32'(range_err), 0);
    fetch(32'h1FFD);
    chk("e_both_m", 32'(misalign_err), 1);
    chk("e_both_r", 32'(range_err), 1);
    chk("e_both_a", err_addr, 32'h1FFD);

    // 5: 4-bit counter saturation
    do_reset();
    for (int i = 0; i < 15; i++) fetch(addr_t'(i * 4));
    chk("sat_15", 32'(s_cnt), 15);
    for (int i = 0; i < 5; i++) fetch(32'h80);
    chk("sat_hold", 32'(s_cnt), 15);
    chk("sat_wide", fetch_cnt, 20);

`ifdef FETCH_MON_TRACE_EN
    // 6: trace history, newest first
    do_reset();
    for (int i = 0; i < 3; i++) fetch(addr_t'(32'h200 + i * 4));
    hist_rd_idx = 3'd3;
    #1;
    chk("tr_empty", hist_rd_addr, 0);
    hist_rd_idx = 3'd0;
    #1;
    chk("tr_new3", hist_rd_addr, 32'h208);
    for (int i = 3; i < 10; i++) fetch(addr_t'(32'h200 + i * 4));
    hist_rd_idx = 3'd0;
    #1;
    chk("tr_idx0", hist_rd_addr, 32'h224);
    hist_rd_idx = 3'd7;
    #1;
    chk("tr_idx7", hist_rd_addr, 32'h208);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
